// File: rtl/i2s_rx_pkg.sv
// Shared types and constants for the I2S capture path.
package i2s_rx_pkg;

  // Default sample width; the deserialiser may be built with a different width.
  localparam int unsigned SAMPLE_W = 16;

  // Pad index map shared with the DPI model wrapper.
  localparam int unsigned I2S_SCK_IDX = 0;
  localparam int unsigned I2S_WS_IDX  = 1;
  localparam int unsigned I2S_SD_IDX  = 2;

  typedef struct packed {
    logic                channel;
    logic [SAMPLE_W-1:0] data;
  } sample_t;

  typedef enum logic [0:0] {
    SYNC  = 1'b0,
    SHIFT = 1'b1
  } rx_state_e;

endpackage

// File: rtl/i2s_rx_if.sv
// Sample stream from the I2S deserialiser to the uDMA-side consumer.
interface i2s_rx_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned LevelW = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_WIDTH-1:0] data_o;
  logic                  channel_o;
  logic                  valid_o;
  logic                  ready_i;
  logic [LevelW-1:0]     level_o;

  modport master (output data_o, output channel_o, output valid_o, output level_o, input ready_i);
  modport slave  (input data_o, input channel_o, input valid_o, input level_o, output ready_i);
endinterface

// File: rtl/i2s_rx_fifo.sv
// Small circular FIFO for completed samples; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module i2s_rx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = i2s_rx_pkg::sample_t
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  T                       wdata_i,
  input  logic                   pop_i,
  output T                       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  T                mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0] level_q, level_d;
  logic            do_push, do_pop;

  assign full_o  = (level_q == LvlW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Pointer and occupancy update; pointers wrap naturally (power-of-2 depth).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (do_push && !do_pop)      level_d = level_q + LvlW'(1);
    else if (!do_push && do_pop) level_d = level_q - LvlW'(1);
  end

  // Storage and pointer registers; storage cleared so the head reads 0 after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/i2s_rx_deser.sv
// I2S receive deserialiser: oversamples the pads, frames standard I2S words
// and queues MSB-aligned left/right samples for the consumer.
module i2s_rx_deser #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      en_i,
  input  logic      clr_i,
  input  logic      i2s_sck_i,
  input  logic      i2s_ws_i,
  input  logic      i2s_sd_i,
  i2s_rx_if.master  out_if,
  output logic      overflow_o,
  output logic      short_err_o
);
  import i2s_rx_pkg::*;

  localparam int unsigned CntW = $clog2(DATA_WIDTH + 2);
  localparam logic [CntW-1:0] CntMax  = CntW'(DATA_WIDTH + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_WIDTH - 1);

  typedef struct packed {
    logic                  channel;
    logic [DATA_WIDTH-1:0] data;
  } word_t;

  logic [2:0]            sck_sync_q, sck_sync_d;
  logic [1:0]            ws_sync_q, ws_sync_d, sd_sync_q, sd_sync_d;
  logic                  state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  ws_prev_q, ws_prev_d;
  logic                  ws_seen_q, ws_seen_d;
  logic                  overflow_q, overflow_d;
  logic                  short_q, short_d;

  logic                  sck_rise, ws, sd, ws_edge;
  logic [DATA_WIDTH-1:0] word_data;
  logic                  push, short_evt, drop;
  logic                  fifo_full, fifo_empty;
  word_t                 push_word, head_word;

  assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
  assign ws       = ws_sync_q[1];
  assign sd       = sd_sync_q[1];
  assign ws_edge  = ws != ws_prev_q;

  // Pad synchronisers; the third SCK stage only feeds rising-edge detection.
  always_comb begin
    sck_sync_d = {sck_sync_q[1:0], i2s_sck_i};
    ws_sync_d  = {ws_sync_q[0], i2s_ws_i};
    sd_sync_d  = {sd_sync_q[0], i2s_sd_i};
  end

  // Framing FSM: a WS change marks the LSB slot of the word in progress.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    ws_prev_d = ws_prev_q;
    ws_seen_d = ws_seen_q;
    push      = 1'b0;
    short_evt = 1'b0;

    // Current bit merged at its MSB-first slot; bits past DATA_WIDTH are dropped.
    word_data = shift_q;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      if (cnt_q == CntW'(DATA_WIDTH - 1 - i)) word_data[i] = sd;
    end

    // WS history tracks the pads even while disabled so resync needs a real edge.
    if (sck_rise) begin
      ws_prev_d = ws;
      ws_seen_d = 1'b1;
    end

    if (!en_i) begin
      state_d = SYNC;
      shift_d = '0;
      cnt_d   = '0;
    end else if (sck_rise) begin
      if (state_q == SYNC) begin
        if (ws_seen_q && ws_edge) begin
          state_d = SHIFT;
          shift_d = '0;
          cnt_d   = '0;
        end
      end else if (ws_edge) begin
        push      = 1'b1;
        short_evt = cnt_q < CntLast;
        shift_d   = '0;
        cnt_d     = '0;
      end else begin
        shift_d = word_data;
        if (cnt_q != CntMax) cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  assign push_word.channel = ws_prev_q;
  assign push_word.data    = word_data;
  assign drop              = push & fifo_full & ~out_if.ready_i;

  // Sticky error flags; a new event in the clearing cycle wins.
  always_comb begin
    overflow_d = clr_i ? 1'b0 : overflow_q;
    short_d    = clr_i ? 1'b0 : short_q;
    if (drop)      overflow_d = 1'b1;
    if (short_evt) short_d    = 1'b1;
  end

  // State registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sck_sync_q <= '0;
      ws_sync_q  <= '0;
      sd_sync_q  <= '0;
      state_q    <= SYNC;
      shift_q    <= '0;
      cnt_q      <= '0;
      ws_prev_q  <= 1'b0;
      ws_seen_q  <= 1'b0;
      overflow_q <= 1'b0;
      short_q    <= 1'b0;
    end else begin
      sck_sync_q <= sck_sync_d;
      ws_sync_q  <= ws_sync_d;
      sd_sync_q  <= sd_sync_d;
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      ws_prev_q  <= ws_prev_d;
      ws_seen_q  <= ws_seen_d;
      overflow_q <= overflow_d;
      short_q    <= short_d;
    end
  end

  i2s_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (word_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .wdata_i (push_word),
    .pop_i   (out_if.ready_i),
    .rdata_o (head_word),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (out_if.level_o)
  );

  assign out_if.data_o    = head_word.data;
  assign out_if.channel_o = head_word.channel;
  assign out_if.valid_o   = ~fifo_empty;
  assign overflow_o       = overflow_q;
  assign short_err_o      = short_q;

endmodule

// File: tb/tb_i2s_rx_deser.sv
// Self-checking bench: drives I2S pads at SCK = clk/8, scoreboards every
// popped sample and checks flags, level and latency at the corner cases.
module tb_i2s_rx_deser;
  import i2s_rx_pkg::*;

  typedef struct {
    logic        ch;
    logic [15:0] data;
  } exp_t;

  typedef struct {
    logic [31:0] val;
    int          len;
    logic [15:0] exp_data;
    logic        exp_short;
  } vec_t;

  logic       clk, rst, en, clr;
  logic [2:0] pads;
  logic       overflow, short_err;
  logic       cur_ch;
  exp_t       exp_q[$];
  vec_t       vecs[8];
  int         nvec, nerr;

  i2s_rx_if #(.DATA_WIDTH(16), .FIFO_DEPTH(4)) out_if ();

  i2s_rx_deser #(
    .DATA_WIDTH (16),
    .FIFO_DEPTH (4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .en_i        (en),
    .clr_i       (clr),
    .i2s_sck_i   (pads[I2S_SCK_IDX]),
    .i2s_ws_i    (pads[I2S_WS_IDX]),
    .i2s_sd_i    (pads[I2S_SD_IDX]),
    .out_if      (out_if),
    .overflow_o  (overflow),
    .short_err_o (short_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    tick(1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
  endtask

  // One word MSB first; the LSB slot carries the next channel's WS.
  // mode 1: check valid latency; 2: ready high on the push edge; 3: clr on the push edge.
  task automatic send_word(input logic [31:0] val, input int len, input bit expect_it,
                           input logic [15:0] exp_data, input int mode);
    logic nxt;
    time  t0;
    int   el;
    if (expect_it) exp_q.push_back('{ch: cur_ch, data: exp_data});
    nxt = ~cur_ch;
    for (int i = len - 1; i >= 0; i--) begin
      pads[I2S_SCK_IDX] = 1'b0;
      pads[I2S_WS_IDX]  = (i == 0) ? nxt : cur_ch;
      pads[I2S_SD_IDX]  = val[i];
      #40;
      pads[I2S_SCK_IDX] = 1'b1;
      t0 = $time;
      if (i == 0 && mode != 0) begin
        tick(2);
        case (mode)
          1: chk("latency_edge2_valid", out_if.valid_o, 0);
          2: out_if.ready_i = 1'b1;
          3: clr = 1'b1;
          default: ;
        endcase
        tick(1);
        case (mode)
          1: chk("latency_edge3_valid", out_if.valid_o, 1);
          2: begin
            out_if.ready_i = 1'b0;
            chk("full_pushpop_level", out_if.level_o, 4);
            chk("full_pushpop_overflow", overflow, 0);
          end
          3: begin
            clr = 1'b0;
            chk("clr_vs_drop_overflow", overflow, 1);
          end
          default: ;
        endcase
      end
      el = int'($time - t0);
      #(40 - el);
    end
    cur_ch = nxt;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    tick(1);
    out_if.ready_i = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      if (exp_q.size() == 0 && !out_if.valid_o) done = 1'b1;
      else tick(1);
    end
    chk("drain_done", done, 1);
    chk("drain_level", out_if.level_o, 0);
    out_if.ready_i = 1'b0;
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    vecs[0] = '{32'h123456, 24, 16'h1234, 1'b0};
    vecs[1] = '{32'hABCDEF, 24, 16'hABCD, 1'b0};
    vecs[2] = '{32'h000FFF, 12, 16'hFFF0, 1'b1};
    vecs[3] = '{32'h008001, 16, 16'h8001, 1'b0};
    vecs[4] = '{32'h010003, 17, 16'h8001, 1'b0};
    vecs[5] = '{32'h007FFF, 15, 16'hFFFE, 1'b1};
    vecs[6] = '{32'h000081,  8, 16'h8100, 1'b1};
    vecs[7] = '{32'h000001,  1, 16'h8000, 1'b1};

    rst = 1'b1;
    en = 1'b1;
    clr = 1'b0;
    cur_ch = 1'b1;
    pads = 3'b010;  // WS high, SCK and SD low
    out_if.ready_i = 1'b0;

    // Scoreboard: each accepted pop is compared with the oldest expected sample.
    fork
      forever begin
        @(negedge clk);
        if (!rst && out_if.valid_o && out_if.ready_i) begin
          if (exp_q.size() == 0) begin
            chk("pop_unexpected_valid", out_if.valid_o, 0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("pop_data", out_if.data_o, e.data);
            chk("pop_channel", out_if.channel_o, e.ch);
          end
        end
      end
    join_none

    tick(3);
    chk("reset_valid", out_if.valid_o, 0);
    chk("reset_level", out_if.level_o, 0);
    chk("reset_data", out_if.data_o, 0);
    chk("reset_overflow", overflow, 0);
    chk("reset_short", short_err, 0);
    rst = 1'b0;
    tick(2);

    // Basic stereo frame after one sync word.
    send_word(32'h5A5A, 16, 1'b0, 16'h0, 0);
    chk("sync_word_dropped_valid", out_if.valid_o, 0);
    send_word(32'hA5C3, 16, 1'b1, 16'hA5C3, 1);
    send_word(32'h0F0F, 16, 1'b1, 16'h0F0F, 0);
    tick(6);
    chk("basic_level", out_if.level_o, 2);
    drain();

    // Word-length table.
    out_if.ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pulse_clr();
      send_word(vecs[i].val, vecs[i].len, 1'b1, vecs[i].exp_data, 0);
      tick(6);
      chk("len_short_err", short_err, vecs[i].exp_short);
      chk("len_overflow", overflow, 0);
    end
    drain();

    // Sticky flag clear.
    chk("short_before_clr", short_err, 1);
    pulse_clr();
    chk("short_after_clr", short_err, 0);

    // Overflow: 5 words with no consumer, only the first 4 kept.
    for (int i = 0; i < 5; i++) send_word(32'hC000 + i, 16, (i < 4), 16'hC000 + 16'(i), 0);
    tick(6);
    chk("ovf_level", out_if.level_o, 4);
    chk("ovf_flag", overflow, 1);
    pulse_clr();
    chk("ovf_after_clr", overflow, 0);
    send_word(32'hC005, 16, 1'b1, 16'hC005, 2);
    send_word(32'hC006, 16, 1'b0, 16'h0, 0);
    tick(6);
    chk("ovf_drop_again", overflow, 1);
    send_word(32'hC007, 16, 1'b0, 16'h0, 3);
    tick(6);
    chk("ovf_level_after_drops", out_if.level_o, 4);
    drain();

    // Enable dropped mid-word: that word is discarded, FIFO kept.
    send_word(32'h1111, 16, 1'b1, 16'h1111, 0);
    tick(6);
    chk("en_level_before", out_if.level_o, 1);
    fork
      send_word(32'h3C3C, 16, 1'b0, 16'h0, 0);
      begin
        #400;
        en = 1'b0;
        tick(20);
        en = 1'b1;
      end
    join
    tick(6);
    chk("en_level_untouched", out_if.level_o, 1);
    send_word(32'h2222, 16, 1'b1, 16'h2222, 0);
    tick(6);
    chk("en_level_after", out_if.level_o, 2);

    // Asynchronous reset with two entries held.
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("areset_valid", out_if.valid_o, 0);
    chk("areset_level", out_if.level_o, 0);
    chk("areset_data", out_if.data_o, 0);
    chk("areset_channel", out_if.channel_o, 0);
    chk("areset_overflow", overflow, 0);
    chk("areset_short", short_err, 0);
    exp_q.delete();
    tick(1);
    rst = 1'b0;
    tick(2);
    send_word(32'h7777, 16, 1'b0, 16'h0, 0);
    tick(6);
    chk("post_reset_no_valid", out_if.valid_o, 0);
    send_word(32'h4321, 16, 1'b1, 16'h4321, 1);
    tick(6);
    chk("post_reset_level", out_if.level_o, 1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
